// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: default queue geometry and the queued entry payload.
package fetch_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT = 4;
  localparam int unsigned PC_W_DEFAULT     = 64;
  localparam int unsigned INSTR_W          = 32;

  typedef struct packed {
    logic [PC_W_DEFAULT-1:0] pc;
    logic [INSTR_W-1:0]      instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Modulo-DEPTH wrap counter used for the fetch queue head and tail pointers.
module fq_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int unsigned AW = $clog2(DEPTH);

  // DEPTH is a power of two, so natural overflow of the AW-bit add is the wrap.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Flip-flop FIFO between instruction fetch and decode, with flush on taken branch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned N     = PC_W_DEFAULT,
  parameter int unsigned IW    = INSTR_W,
  parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [N-1:0]           in_pc,
  input  logic [IW-1:0]          in_instr,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [N-1:0]           out_pc,
  output logic [IW-1:0]          out_instr,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          push;
  logic          pop;

  assign in_ready  = !reset && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  fq_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (pop),
    .ptr   (head)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .inc   (push),
    .ptr   (tail)
  );

  // Occupancy: flush wins over any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; a flushed push must not land so later entries stay clean.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[tail]    <= in_pc;
      instr_mem[tail] <= in_instr;
    end
  end

  assign out_pc    = out_valid ? pc_mem[head]    : '0;
  assign out_instr = out_valid ? instr_mem[head] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard queue modelling the expected FIFO contents.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = FQ_DEPTH_DEFAULT;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    flush = 1'b0;
  logic                    in_valid = 1'b0;
  logic [PC_W_DEFAULT-1:0] in_pc = '0;
  logic [INSTR_W-1:0]      in_instr = '0;
  logic                    in_ready;
  logic                    out_valid;
  logic [PC_W_DEFAULT-1:0] out_pc;
  logic [INSTR_W-1:0]      out_instr;
  logic                    out_ready = 1'b0;
  logic [CW-1:0]           count;

  int n_cmp = 0;
  int n_err = 0;
  fq_entry_t sb [$];

  fetch_queue #(.N(PC_W_DEFAULT), .IW(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_ready (out_ready),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [INSTR_W-1:0] mk_instr(input logic [PC_W_DEFAULT-1:0] pc);
    return 32'hA5C0_0013 ^ pc[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs against the scoreboard before the edge, then advance the model.
  task automatic cyc(input logic v, input logic [63:0] pc, input logic rdy,
                     input logic fl, input logic rst);
    fq_entry_t e;
    logic do_push;
    logic do_pop;
    reset = rst; flush = fl; in_valid = v; in_pc = pc; in_instr = mk_instr(pc); out_ready = rdy;
    #1;
    chk("in_ready",  64'(in_ready),  64'(!rst && (sb.size() < DEPTH)));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("count",     64'(count),     64'(sb.size()));
    chk("out_pc",    out_pc,         (sb.size() != 0) ? sb[0].pc : 64'h0);
    chk("out_instr", 64'(out_instr), (sb.size() != 0) ? 64'(sb[0].instr) : 64'h0);
    do_pop  = (sb.size() != 0) && rdy;
    do_push = v && (sb.size() < DEPTH);
    if (rst || fl) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) begin
        e.pc = pc; e.instr = mk_instr(pc);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [63:0] drain_pc [4];

  initial begin
    drain_pc = '{64'h0, 64'h4, 64'h8, 64'hC};

    // Reset, then fill to full with decode stalled; a fifth offer is ignored.
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_out_pc", out_pc, 64'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 64'(4 * i), 1'b0, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h10, 1'b0, 1'b0, 1'b0);
    chk("full_hold_count", 64'(count), 64'd4);

    // Drain on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", out_pc, drain_pc[i]);
      cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    end
    chk("drained_valid", 64'(out_valid), 64'd0);
    chk("drained_pc", out_pc, 64'h0);

    // Steady push+pop at occupancy 2; pointers wrap several times.
    cyc(1'b1, 64'h100, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h104, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 64'(32'h108 + 4 * i), 1'b1, 1'b0, 1'b0);
    chk("stream_count", 64'(count), 64'd2);
    chk("stream_head", out_pc, 64'h128);

    // Reach three entries, then flush alongside a push of 0x40.
    cyc(1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 64'(count), 64'd3);
    cyc(1'b1, 64'h40, 1'b1, 1'b1, 1'b0);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b1, 64'h44, 1'b0, 1'b0, 1'b0);
    chk("post_flush_head", out_pc, 64'h44);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Push into empty: visible only after the edge.
    cyc(1'b1, 64'h20, 1'b0, 1'b0, 1'b0);
    chk("empty_latency_valid", 64'(out_valid), 64'd1);
    chk("empty_latency_pc", out_pc, 64'h20);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream with push and pop both asserted.
    cyc(1'b1, 64'h300, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 64'h304, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 64'(count), 64'd2);
    cyc(1'b1, 64'h308, 1'b1, 1'b0, 1'b1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 64'h30C, 1'b0, 1'b0, 1'b0);
    chk("post_reset_head", out_pc, 64'h30C);
    cyc(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter N, default 64, meaning PC width in bits.
REQ-002 SHALL have parameter IW, default 32, meaning instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 4, meaning entry count; legal values are powers of two >= 2.
REQ-004 SHALL use one clock; reset is synchronous and active-high; the ports are named clk and reset.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port flush, input, 1 bit: discards all entries (taken branch, PCSrc asserted).
REQ-008 SHALL have port in_valid, input, 1 bit: the fetch side offers an entry.
REQ-009 SHALL have port in_pc, input, N bits: PC of the offered instruction (imem address).
REQ-010 SHALL have port in_instr, input, IW bits: the offered instruction word.
REQ-011 SHALL have port in_ready, output, 1 bit: the queue accepts an entry this cycle.
REQ-012 SHALL have port out_valid, output, 1 bit: a head entry is presented to decode.
REQ-013 SHALL have port out_pc, output, N bits: PC of the head entry.
REQ-014 SHALL have port out_instr, output, IW bits: instruction of the head entry.
REQ-015 SHALL have port out_ready, input, 1 bit: decode consumes the head this cycle.
REQ-016 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-017 SHALL push when in_valid && in_ready, writing {in_pc,in_instr} at the tail.
REQ-018 SHALL pop when out_valid && out_ready, advancing the head.
REQ-019 SHALL keep FIFO order; entries are never reordered or duplicated.
REQ-020 SHALL drive in_ready = !reset && (count < DEPTH), with no combinational dependence on out_ready.
REQ-021 SHALL drive out_valid = (count != 0), registered state only, with no push-to-output bypass.
REQ-022 SHALL have a latency of 1 cycle from push to out_valid when the queue was empty.
REQ-023 SHALL drive out_pc and out_instr to 0 when count == 0, and to the head entry otherwise.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop; count SHALL otherwise increment on push and decrement on pop.
REQ-025 SHALL wrap head and tail pointers modulo DEPTH; count == DEPTH means full and count == 0 means empty.
REQ-026 SHALL, on flush, set count and both pointers to 0 at the next edge; flush overrides a same-cycle push and a same-cycle pop, and the offered entry is discarded.
REQ-027 SHALL ignore in_valid while full; the producer holds its data, and no entry is lost or overwritten.
REQ-028 SHALL hold out_pc and out_instr stable while out_valid && !out_ready.

Reset
REQ-029 SHALL, when reset is high at a clk edge, clear count and both pointers to 0, so that out_valid=0, out_pc=0, out_instr=0 and count=0.
REQ-030 SHALL give reset priority over flush, push and pop; reset mid-stream discards all entries, and in_ready is 0 while reset is high.
REQ-031 SHALL NOT require the storage array to be reset; its contents are unobservable when count == 0.

Structure
REQ-032 SHALL place FQ_DEPTH_DEFAULT, INSTR_W and the typedef fq_entry_t {pc, instr} in the shared package fetch_pkg.
REQ-033 SHALL implement the pointers with one sub-module, fq_ptr (a modulo-DEPTH wrap counter with increment and clear inputs), instantiated for the head and for the tail.
REQ-034 SHALL use flip-flop storage only; no memory macros.

Verification
REQ-035 Bench SHALL run this scenario: reset, then push PC=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a 5th push with PC=0x10 is ignored.
REQ-036 Bench SHALL run this scenario: drain with out_ready=1 -> out_pc sequence is 0x0,0x4,0x8,0xC on consecutive cycles, then out_valid=0 and out_pc=0.
REQ-037 Bench SHALL run this scenario: continuous push and pop at count=2 for 10 cycles -> count stays 2 and pointers wrap past DEPTH with order preserved.
REQ-038 Bench SHALL run this scenario: with count=3, assert flush together with a push of PC=0x40 -> next cycle count=0 and out_valid=0; PC=0x40 never appears at the output.
REQ-039 Bench SHALL run this scenario: push PC=0x20 into an empty queue -> out_valid rises on the next cycle, not in the same cycle.
REQ-040 Bench SHALL run this scenario: assert reset with count=2 while a push and pop are also asserted -> count=0, out_valid=0 and in_ready=0 during reset, and in_ready=1 in the cycle after reset is released.
